// File: rtl/regfile_nport.sv
// Multi-port register file: NRD registered read ports, NWR write ports, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to matching reads.
module regfile_nport #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_valid,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];
  logic [WIDTH-1:0] rd_word  [NRD];

  // Later write ports overwrite earlier ones, so the highest-index writer wins.
  // Entries are matched by value, so address 0 and out-of-range addresses never hit.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) mem_next[e] = mem[e];
    mem_next[0] = '0;
    for (int e = 1; e < DEPTH; e++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(e)))
          mem_next[e] = wr_data[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_word[p] = '0;
      for (int e = 1; e < DEPTH; e++) begin
        if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
`ifdef REGFILE_BYPASS_EN
          rd_word[p] = mem_next[e];
`else
          rd_word[p] = mem[e];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= mem_next[e];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int p = 0; p < NRD; p++) begin
        if (rd_en[p]) rd_data[p*WIDTH +: WIDTH] <= rd_word[p];
      end
    end
  end

endmodule
